tdm_mux_scanner: RTL and testbench
==================================

Name: tdm_mux_scanner

Overview:
- Parametrised, registered N-channel time-division multiplexer; successor to the combinational 4:1 mux.
- Auto-scans input channels with a programmable dwell, or follows an external select in manual mode.
- Presents one registered W-bit sample per cycle, tagged with its channel number and frame markers.
- Sits between parallel channel sources and a single serial consumer, e.g. a logger or shared datapath.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 1, bits per channel.
- DWELL, 1, enabled cycles spent on each channel in auto mode (>=1).
- SEL_W, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance/sample enable.
- mode  input  1  0 = auto scan, 1 = manual select.
- sel_in  input  SEL_W  manual channel select.
- a  input  N_CH*WIDTH  flattened channel data; channel k = a[k*WIDTH +: WIDTH].
- y  output  WIDTH  registered selected sample.
- ch  output  SEL_W  channel index that y was taken from.
- valid  output  1  y/ch hold a fresh sample this cycle.
- frame_start  output  1  y is the first sample of channel 0's dwell.

Behaviour:
- Reset (async assert, sync release): y=0, ch=0, valid=0, frame_start=0, internal cur_ch=0, dwell_cnt=0, FSM=IDLE.
- FSM states: IDLE (en=0), SCAN (en=1, mode=0), MANUAL (en=1, mode=1). The state is re-evaluated every cycle from en/mode; no extra transition latency.
- IDLE:
  - cur_ch, dwell_cnt, y and ch hold their values.
  - valid=0, frame_start=0.
- SCAN, each edge:
  - y<=a[cur_ch], ch<=cur_ch, valid<=1.
  - frame_start<=(cur_ch==0 && dwell_cnt==0).
  - If dwell_cnt==DWELL-1: dwell_cnt<=0 and cur_ch<=next channel (N_CH-1 wraps to 0). Otherwise dwell_cnt<=dwell_cnt+1.
- MANUAL, each edge:
  - If sel_in<N_CH: y<=a[sel_in], ch<=sel_in, cur_ch<=sel_in, valid<=1.
  - If sel_in>=N_CH (non-power-of-2 N_CH): y, ch and cur_ch hold, valid<=0.
  - dwell_cnt<=0; frame_start<=0.
- MANUAL->SCAN: scanning resumes at cur_ch with dwell_cnt=0, so the current channel gets a full dwell.
- Latency: one cycle from a/sel_in at an edge to y/ch/valid.
- Outputs are registers only; no combinational path from inputs to outputs.
- Reset asserted mid-dwell: state clears immediately; the first enabled cycle after release samples channel 0 with frame_start=1.
- en dropping mid-dwell: dwell_cnt is frozen, not reset. The dwell completes after the remaining enabled cycles.
- DWELL=1: channel advances every enabled cycle; frame_start fires once every N_CH enabled cycles.

Optional Feature:
- Macro: TDM_MUX_SCANNER_CH_MASK_EN.
- Defined:
  - Adds input ch_mask [N_CH]; 1 = skip channel.
  - In SCAN, the next channel is the next unmasked index in cyclic order after cur_ch.
  - If cur_ch itself is masked on an edge, no sample is emitted (valid<=0) and cur_ch advances to the next unmasked channel.
  - If all channels are masked: valid=0, frame_start=0, cur_ch and dwell_cnt hold.
  - frame_start fires on the lowest-index unmasked channel's first dwell sample.
  - MANUAL mode ignores the mask.
- Undefined: no ch_mask port; all N_CH channels are scanned.

Test Plan:
- N_CH=4, WIDTH=1, DWELL=1; a=4'b1010, en=1, mode=0 from reset:
  - ch sequence 0,1,2,3,0,…; y sequence 0,1,0,1,…
  - valid=1 from the first edge; frame_start=1 on every 4th sample, starting with the first.
- N_CH=4, WIDTH=8, DWELL=3; a={8'h44,8'h33,8'h22,8'h11}:
  - y = 11,11,11,22,22,22,33,33,33,44,44,44, then repeats.
  - frame_start high only on the first 8'h11 of each frame.
- DWELL=3; drop en for 5 cycles after the second sample of channel 1:
  - valid=0 while en is low; y holds 8'h22.
  - After en returns, exactly one more 8'h22 is emitted, then 8'h33.
- mode=1, sel_in=2 then 0, with the 8-bit data above:
  - y=8'h33, ch=2, then y=8'h11, ch=0, each one cycle after sel_in.
  - frame_start stays 0.
  - Switching to mode=0 yields three 8'h11 samples, then 8'h22.
- N_CH=3, manual sel_in=3 -> valid=0; y and ch keep their previous values.
- Assert rst_n=0 asynchronously mid-dwell on channel 2:
  - y=0, ch=0, valid=0 before the next edge.
  - After release, the first sample is channel 0 with frame_start=1.
- With TDM_MUX_SCANNER_CH_MASK_EN, N_CH=4, DWELL=1:
  - ch_mask=4'b0101 -> ch sequence 1,3,1,3; frame_start on ch=1.
  - ch_mask=4'b1111 -> valid stays 0.

Source files
------------

// File: rtl/tdm_mux_scanner.sv
// Registered N-channel TDM multiplexer: auto-scan with programmable dwell or manual select.
// Optional channel skip mask enabled by defining TDM_MUX_SCANNER_CH_MASK_EN.
module tdm_mux_scanner #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [N_CH*WIDTH-1:0] a,
`ifdef TDM_MUX_SCANNER_CH_MASK_EN
    input  logic [N_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]      y,
    output logic [SEL_W-1:0]      ch,
    output logic                  valid,
    output logic                  frame_start
);

    localparam int               DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, MANUAL} state_t;
    state_t state;

    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    logic [WIDTH-1:0] a_ch [N_CH];
    logic [WIDTH-1:0] cur_dat, man_dat;
    logic [SEL_W-1:0] nxt_ch, first_ch;
    logic             cur_skip, all_msk, sel_ok, dwell_end;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign a_ch[k] = a[k*WIDTH +: WIDTH];
    end

    // Loop muxes keep out-of-range indices (non-power-of-2 N_CH) from reading past the array.
    always_comb begin
        cur_dat = '0;
        man_dat = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == SEL_W'(k)) cur_dat = a_ch[k];
            if (sel_in == SEL_W'(k))   man_dat = a_ch[k];
        end
    end

    assign sel_ok    = (int'(sel_in) < N_CH);
    assign dwell_end = (dwell_q == LAST_DW);

`ifdef TDM_MUX_SCANNER_CH_MASK_EN
    logic [SEL_W-1:0] nxt_hi;
    logic             hit_hi;

    // Descending walk: last hit above cur_ch is the nearest one, last hit overall is the lowest.
    always_comb begin
        nxt_hi   = '0;
        hit_hi   = 1'b0;
        first_ch = '0;
        cur_skip = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (!ch_mask[k]) begin
                if (SEL_W'(k) > cur_ch_q) begin
                    nxt_hi = SEL_W'(k);
                    hit_hi = 1'b1;
                end
                first_ch = SEL_W'(k);
            end
            if (cur_ch_q == SEL_W'(k)) cur_skip = ch_mask[k];
        end
        nxt_ch = hit_hi ? nxt_hi : first_ch;
    end

    assign all_msk = &ch_mask;
`else
    assign nxt_ch   = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
    assign first_ch = '0;
    assign cur_skip = 1'b0;
    assign all_msk  = 1'b0;
`endif

    always_comb begin
        state = IDLE;
        if (en) state = mode ? MANUAL : SCAN;
    end

    always_comb begin
        y_d      = y_q;
        ch_d     = ch_q;
        valid_d  = 1'b0;
        fs_d     = 1'b0;
        cur_ch_d = cur_ch_q;
        dwell_d  = dwell_q;
        case (state)
            SCAN: begin
                if (!all_msk) begin
                    if (cur_skip) begin
                        cur_ch_d = nxt_ch;
                        dwell_d  = '0;
                    end else begin
                        y_d     = cur_dat;
                        ch_d    = cur_ch_q;
                        valid_d = 1'b1;
                        fs_d    = (cur_ch_q == first_ch) && (dwell_q == '0);
                        if (dwell_end) begin
                            dwell_d  = '0;
                            cur_ch_d = nxt_ch;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
            end
            MANUAL: begin
                // Clearing the dwell here gives the channel a full dwell on return to SCAN.
                dwell_d = '0;
                if (sel_ok) begin
                    y_d      = man_dat;
                    ch_d     = sel_in;
                    cur_ch_d = sel_in;
                    valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            cur_ch_q <= '0;
            dwell_q  <= '0;
        end else begin
            y_q      <= y_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            cur_ch_q <= cur_ch_d;
            dwell_q  <= dwell_d;
        end
    end

    assign y           = y_q;
    assign ch          = ch_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Scoreboard bench for tdm_mux_scanner: three configurations, directed vectors.
module tb_tdm_mux_scanner;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ch;
        logic       fs;
    } exp_t;

    logic clk, rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q1[$], q2[$], q3[$];
    exp_t m1, m2, m3;

    // u1: N_CH=4, WIDTH=1, DWELL=1
    logic       en1, mode1, y1, v1, fs1;
    logic [1:0] sel1, ch1;
    logic [3:0] a1, mask1;
    // u2: N_CH=4, WIDTH=8, DWELL=3
    logic        en2, mode2, v2, fs2;
    logic [1:0]  sel2, ch2;
    logic [31:0] a2;
    logic [7:0]  y2;
    logic [3:0]  mask2;
    // u3: N_CH=3, WIDTH=8, DWELL=1
    logic        en3, mode3, v3, fs3;
    logic [1:0]  sel3, ch3;
    logic [23:0] a3;
    logic [7:0]  y3;
    logic [2:0]  mask3;

    tdm_mux_scanner #(.N_CH(4), .WIDTH(1), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel_in(sel1), .a(a1),
`ifdef TDM_MUX_SCANNER_CH_MASK_EN
        .ch_mask(mask1),
`endif
        .y(y1), .ch(ch1), .valid(v1), .frame_start(fs1));

    tdm_mux_scanner #(.N_CH(4), .WIDTH(8), .DWELL(3)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel_in(sel2), .a(a2),
`ifdef TDM_MUX_SCANNER_CH_MASK_EN
        .ch_mask(mask2),
`endif
        .y(y2), .ch(ch2), .valid(v2), .frame_start(fs2));

    tdm_mux_scanner #(.N_CH(3), .WIDTH(8), .DWELL(1)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel_in(sel3), .a(a3),
`ifdef TDM_MUX_SCANNER_CH_MASK_EN
        .ch_mask(mask3),
`endif
        .y(y3), .ch(ch3), .valid(v3), .frame_start(fs3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected valid sample, expected none", nm);
    endtask

    // Monitors: pop one expectation per valid sample, checked on the falling edge.
    always @(negedge clk) if (rst_n && v1) begin
        if (q1.size() == 0) unexpected("u1 sample");
        else begin
            m1 = q1.pop_front();
            check("u1 sample", {21'd0, 7'd0, y1, ch1, fs1}, {21'd0, m1});
        end
    end

    always @(negedge clk) if (rst_n && v2) begin
        if (q2.size() == 0) unexpected("u2 sample");
        else begin
            m2 = q2.pop_front();
            check("u2 sample", {21'd0, y2, ch2, fs2}, {21'd0, m2});
        end
    end

    always @(negedge clk) if (rst_n && v3) begin
        if (q3.size() == 0) unexpected("u3 sample");
        else begin
            m3 = q3.pop_front();
            check("u3 sample", {21'd0, y3, ch3, fs3}, {21'd0, m3});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s1(input logic y, input logic [1:0] c, input logic f);
        exp_t e;
        e.y = {7'd0, y}; e.ch = c; e.fs = f;
        q1.push_back(e);
        tick();
    endtask

    task automatic s2(input logic [7:0] y, input logic [1:0] c, input logic f);
        exp_t e;
        e.y = y; e.ch = c; e.fs = f;
        q2.push_back(e);
        tick();
    endtask

    task automatic s3(input logic [7:0] y, input logic [1:0] c, input logic f);
        exp_t e;
        e.y = y; e.ch = c; e.fs = f;
        q3.push_back(e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en1 = 0; mode1 = 0; sel1 = 0; a1 = 4'b1010; mask1 = 4'b0000;
        en2 = 0; mode2 = 0; sel2 = 0; a2 = {8'h44, 8'h33, 8'h22, 8'h11}; mask2 = 4'b0000;
        en3 = 0; mode3 = 0; sel3 = 0; a3 = {8'hCC, 8'hBB, 8'hAA}; mask3 = 3'b000;

        #12;
        check("reset u1", {28'd0, y1, ch1, v1}, 32'd0);
        check("reset u2", {21'd0, y2, ch2, v2}, 32'd0);
        check("reset u3", {21'd0, y3, ch3, v3}, 32'd0);
        check("reset fs", {29'd0, fs1, fs2, fs3}, 32'd0);
        tick();
        rst_n = 1'b1;

        // DWELL=1 scan over a=1010
        en1 = 1'b1;
        for (int i = 0; i < 8; i++) s1((i % 2) == 1, 2'(i % 4), (i % 4) == 0);
        en1 = 1'b0;

`ifdef TDM_MUX_SCANNER_CH_MASK_EN
        mask1 = 4'b0101;
        en1 = 1'b1;
        tick();
        @(negedge clk);
        check("mask skip ch0 valid", {31'd0, v1}, 32'd0);
        s1(1'b1, 2'd1, 1'b1);
        s1(1'b1, 2'd3, 1'b0);
        s1(1'b1, 2'd1, 1'b1);
        s1(1'b1, 2'd3, 1'b0);
        mask1 = 4'b1111;
        repeat (3) begin
            tick();
            @(negedge clk);
            check("all masked valid", {30'd0, v1, fs1}, 32'd0);
        end
        en1 = 1'b0;
        mask1 = 4'b0000;
`endif

        // DWELL=3 scan: one full frame plus the start of the next
        en2 = 1'b1;
        for (int i = 0; i < 15; i++) s2(8'(17 * ((i / 3) % 4 + 1)), 2'((i / 3) % 4), (i % 12) == 0);
        s2(8'h22, 2'd1, 1'b0);
        s2(8'h22, 2'd1, 1'b0);
        en2 = 1'b0;
        repeat (5) begin
            tick();
            @(negedge clk);
            check("en low valid", {31'd0, v2}, 32'd0);
            check("en low y hold", {24'd0, y2}, 32'h22);
        end
        en2 = 1'b1;
        s2(8'h22, 2'd1, 1'b0);
        s2(8'h33, 2'd2, 1'b0);
        s2(8'h33, 2'd2, 1'b0);
        s2(8'h33, 2'd2, 1'b0);

        // Manual select, then back to scan from the selected channel
        mode2 = 1'b1; sel2 = 2'd2;
        s2(8'h33, 2'd2, 1'b0);
        sel2 = 2'd0;
        s2(8'h11, 2'd0, 1'b0);
        mode2 = 1'b0;
        s2(8'h11, 2'd0, 1'b1);
        s2(8'h11, 2'd0, 1'b0);
        s2(8'h11, 2'd0, 1'b0);
        s2(8'h22, 2'd1, 1'b0);
        s2(8'h22, 2'd1, 1'b0);
        s2(8'h22, 2'd1, 1'b0);
        s2(8'h33, 2'd2, 1'b0);

        // Async reset in the middle of channel 2's dwell
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async reset u2", {20'd0, y2, ch2, v2, fs2}, 32'd0);
        tick();
        rst_n = 1'b1;
        s2(8'h11, 2'd0, 1'b1);
        s2(8'h11, 2'd0, 1'b0);
        en2 = 1'b0;

        // N_CH=3: out-of-range select holds, then scan wraps 2 -> 0
        en3 = 1'b1; mode3 = 1'b1; sel3 = 2'd1;
        s3(8'hBB, 2'd1, 1'b0);
        sel3 = 2'd3;
        tick();
        @(negedge clk);
        check("sel oob valid", {31'd0, v3}, 32'd0);
        check("sel oob hold", {22'd0, y3, ch3}, {22'd0, 8'hBB, 2'd1});
        sel3 = 2'd2;
        s3(8'hCC, 2'd2, 1'b0);
        mode3 = 1'b0;
        s3(8'hCC, 2'd2, 1'b0);
        s3(8'hAA, 2'd0, 1'b1);
        s3(8'hBB, 2'd1, 1'b0);
        s3(8'hCC, 2'd2, 1'b0);
        s3(8'hAA, 2'd0, 1'b1);
        en3 = 1'b0;

        repeat (3) tick();
        check("u1 queue drained", q1.size(), 32'd0);
        check("u2 queue drained", q2.size(), 32'd0);
        check("u3 queue drained", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
